brightness_ramp: RTL and testbench
==================================

# brightness_ramp

Downstream consumer of the brightness command path. It latches each new brightness level delivered with a one-cycle `brightness_change_en` strobe and moves the applied level toward it in frame-aligned single-LSB steps. The applied level drives the display scan/OE gating logic, so brightness changes fade instead of jumping and never change mid-frame.

## Interface
- `BRIGHTNESS_WIDTH`, default 8: width of every level signal.
- `STEP_DIV`, default 4: frame ticks per one-LSB step. Legal range is 1..255.
- `RESET_LEVEL`, default all-ones of `BRIGHTNESS_WIDTH`: applied and target level after reset.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `brightness_in`  in  `BRIGHTNESS_WIDTH`  requested level. Sampled only when `brightness_change_en`=1.
- `brightness_change_en`  in  1  single-cycle request strobe.
- `frame_tick`  in  1  single-cycle pulse at each frame boundary, from the scan controller.
- `target_level`  out  `BRIGHTNESS_WIDTH`  latched request.
- `current_level`  out  `BRIGHTNESS_WIDTH`  applied level, consumed by the OE/PWM gating.
- `ramping`  out  1  high while `current_level` ≠ `target_level`.
- `settled`  out  1  one-cycle pulse when `current_level` reaches `target_level`.

## Operation
- States: IDLE, RAMP.
- Reset (any cycle, including mid-ramp):
  - `current_level` = `target_level` = `RESET_LEVEL`.
  - `ramping`=0, `settled`=0, internal divider=0, state IDLE.
- IDLE, with `brightness_change_en`=1:
  - `target_level`←`brightness_in`.
  - If `brightness_in` ≠ `current_level`: go to RAMP and clear the divider.
  - Otherwise stay in IDLE and pulse `settled`.
- RAMP, on each `frame_tick`: increment the divider.
  - When the divider equals `STEP_DIV-1`: clear the divider and move `current_level` one LSB toward `target_level` (+1 if below, −1 if above).
  - If the stepped value equals `target_level`: go to IDLE and pulse `settled` in the same cycle `current_level` updates.
- RAMP, with `brightness_change_en`=1 (retarget):
  - `target_level`←`brightness_in`. The divider is kept, and direction is re-evaluated on the next step.
  - If `brightness_in` equals `current_level`: go to IDLE and pulse `settled`.
- `brightness_change_en` and `frame_tick` in the same cycle: the request wins. That tick is ignored entirely; the divider does not increment and no step occurs.
- Arithmetic:
  - A step never overshoots, because it stops on equality.
  - No wrap-around: 0 never steps down and all-ones never steps up. This is guaranteed because the step direction always points at the target.
- `frame_tick` in IDLE: ignored; the divider stays 0.
- `ramping` is registered and equals (state==RAMP).

## Timing
- Request strobe at cycle t:
  - `target_level` valid at t+1.
  - `ramping`=1 at t+1 when a ramp is needed.
  - `settled`=1 at t+1 when no ramp is needed.
- Step latency: `current_level` updates the cycle after the qualifying `frame_tick`.
- `current_level` changes only in the cycle after a `frame_tick`, so it is frame-synchronous.
- Full ramp of distance D takes D×`STEP_DIV` frame ticks. With `STEP_DIV`=1, every tick steps.
- `settled` lasts exactly one cycle and asserts together with the final `current_level` value.
- Back-to-back strobes on consecutive cycles are legal; the last one wins.

## Configuration
- Macro: `BRIGHTNESS_RAMP_EN`.
- Defined: stepped ramp as described above.
- Undefined:
  - The divider is removed and `STEP_DIV` is ignored.
  - In RAMP, the first honoured `frame_tick` sets `current_level`←`target_level`, returns to IDLE and pulses `settled`.
  - Request and reset behaviour are unchanged. The update stays frame-aligned with one-tick latency.

## Test plan
- Reset, with `RESET_LEVEL`=8'hFF: `current_level`=`target_level`=8'hFF and `ramping`=`settled`=0. Assert reset mid-ramp and check that the same values return in the next cycle.
- Ramp up, `STEP_DIV`=2: from 8'h10, request 8'h14.
  - `current_level` reads 8'h11/12/13/14 after ticks 2/4/6/8.
  - `settled` pulses once, with the 8'h14 update.
  - `ramping` is high from the cycle after the strobe until that point.
- Retarget mid-ramp: from 8'h20 toward 8'h28, request 8'h1E once `current_level`=8'h22.
  - `current_level` steps 8'h21, 8'h20, 8'h1F, 8'h1E.
  - There is no overshoot and exactly one `settled` pulse.
- Request equal to the current level (8'h40 → 8'h40): `ramping` stays 0, `settled` pulses at t+1, and no tick causes a change.
- Strobe and `frame_tick` in the same cycle, with `STEP_DIV`=1: no step on that tick. The first step follows the next tick.
- `BRIGHTNESS_RAMP_EN` undefined: request 8'h00 from 8'hFF.
  - `current_level` holds 8'hFF until the next `frame_tick`, then becomes 8'h00 one cycle later.
  - `settled` pulses with that update.

Source files
------------

// File: rtl/brightness_ramp.sv
// ============================================================================
// brightness_ramp : frame-aligned fade of the applied brightness level
// Optional feature macro: BRIGHTNESS_RAMP_EN (defined = stepped ramp,
// undefined = jump to target on the next frame tick).
// Revision: 1.0
// ============================================================================
`default_nettype none

module brightness_ramp #(
  parameter int                          BRIGHTNESS_WIDTH = 8,
  parameter int                          STEP_DIV         = 4,
  parameter logic [BRIGHTNESS_WIDTH-1:0] RESET_LEVEL      = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BRIGHTNESS_WIDTH-1:0] brightness_in,
  input  logic                        brightness_change_en,
  input  logic                        frame_tick,
  output logic [BRIGHTNESS_WIDTH-1:0] target_level,
  output logic [BRIGHTNESS_WIDTH-1:0] current_level,
  output logic                        ramping,
  output logic                        settled
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  if (STEP_DIV < 1 || STEP_DIV > 255) begin : g_step_div_range_check
    $error("brightness_ramp: STEP_DIV must be in 1..255");
  end

  state_t                      state_q, state_d;
  logic [BRIGHTNESS_WIDTH-1:0] current_q, current_d;
  logic [BRIGHTNESS_WIDTH-1:0] target_q, target_d;
  logic                        ramping_q, ramping_d;
  logic                        settled_q, settled_d;

`ifdef BRIGHTNESS_RAMP_EN
  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

  logic [7:0]                  div_q, div_d;
  logic [BRIGHTNESS_WIDTH-1:0] step_level;

  // Direction always points at the target, so the step can never wrap.
  assign step_level = (current_q < target_q) ? current_q + 1'b1 : current_q - 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    current_d = current_q;
    target_d  = target_q;
    settled_d = 1'b0;
`ifdef BRIGHTNESS_RAMP_EN
    div_d     = div_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (brightness_change_en) begin
          target_d = brightness_in;
          if (brightness_in != current_q) begin
            state_d = RAMP;
`ifdef BRIGHTNESS_RAMP_EN
            div_d   = 8'd0;
`endif
          end else begin
            settled_d = 1'b1;
          end
        end
      end

      RAMP: begin
        // A request in the same cycle as a tick swallows that tick.
        if (brightness_change_en) begin
          target_d = brightness_in;
          if (brightness_in == current_q) begin
            state_d   = IDLE;
            settled_d = 1'b1;
          end
        end else if (frame_tick) begin
`ifdef BRIGHTNESS_RAMP_EN
          if (div_q == DIV_LAST) begin
            div_d     = 8'd0;
            current_d = step_level;
            if (step_level == target_q) begin
              state_d   = IDLE;
              settled_d = 1'b1;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
`else
          current_d = target_q;
          state_d   = IDLE;
          settled_d = 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    ramping_d = (state_d == RAMP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      current_q <= RESET_LEVEL;
      target_q  <= RESET_LEVEL;
      ramping_q <= 1'b0;
      settled_q <= 1'b0;
`ifdef BRIGHTNESS_RAMP_EN
      div_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      current_q <= current_d;
      target_q  <= target_d;
      ramping_q <= ramping_d;
      settled_q <= settled_d;
`ifdef BRIGHTNESS_RAMP_EN
      div_q     <= div_d;
`endif
    end
  end

  assign target_level  = target_q;
  assign current_level = current_q;
  assign ramping       = ramping_q;
  assign settled       = settled_q;

endmodule

`default_nettype wire

// File: tb/tb_brightness_ramp.sv
// ============================================================================
// tb_brightness_ramp : directed self-checking bench for brightness_ramp.
// Instance 0 uses STEP_DIV=2, instance 1 uses STEP_DIV=1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_brightness_ramp;

  logic       clk = 1'b0;
  logic       reset;
  logic       en   [2];
  logic [7:0] bin  [2];
  logic       tick [2];
  logic [7:0] cur  [2];
  logic [7:0] tgt  [2];
  logic       ramp [2];
  logic       setl [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  brightness_ramp #(.BRIGHTNESS_WIDTH(8), .STEP_DIV(2), .RESET_LEVEL(8'hFF)) u_dut0 (
    .clk(clk), .reset(reset), .brightness_in(bin[0]), .brightness_change_en(en[0]),
    .frame_tick(tick[0]), .target_level(tgt[0]), .current_level(cur[0]),
    .ramping(ramp[0]), .settled(setl[0])
  );

  brightness_ramp #(.BRIGHTNESS_WIDTH(8), .STEP_DIV(1), .RESET_LEVEL(8'hFF)) u_dut1 (
    .clk(clk), .reset(reset), .brightness_in(bin[1]), .brightness_change_en(en[1]),
    .frame_tick(tick[1]), .target_level(tgt[1]), .current_level(cur[1]),
    .ramping(ramp[1]), .settled(setl[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input logic [7:0] lvl);
    en[i]  = 1'b1;
    bin[i] = lvl;
    cyc();
    en[i]  = 1'b0;
  endtask

  task automatic do_tick(input int i);
    tick[i] = 1'b1;
    cyc();
    tick[i] = 1'b0;
  endtask

  task automatic goto_level(input int i, input logic [7:0] lvl);
    int n;
    strobe(i, lvl);
    n = 0;
    while ((cur[i] !== lvl || ramp[i] !== 1'b0) && n < 1000) begin
      do_tick(i);
      n++;
    end
    check("goto_level", {24'd0, cur[i]}, {24'd0, lvl});
  endtask

  initial begin
    int settle_cnt;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; bin[i] = 8'h00; tick[i] = 1'b0;
    end
    cyc();
    cyc();
    reset = 1'b0;

    check("rst_cur",     {24'd0, cur[0]}, 32'hFF);
    check("rst_tgt",     {24'd0, tgt[0]}, 32'hFF);
    check("rst_ramping", {31'd0, ramp[0]}, 32'd0);
    check("rst_settled", {31'd0, setl[0]}, 32'd0);
    check("rst_cur1",    {24'd0, cur[1]}, 32'hFF);

`ifdef BRIGHTNESS_RAMP_EN
    // Ramp up 0x10 -> 0x14 with STEP_DIV=2.
    goto_level(0, 8'h10);
    cyc();
    strobe(0, 8'h14);
    check("up_tgt",     {24'd0, tgt[0]}, 32'h14);
    check("up_ramping", {31'd0, ramp[0]}, 32'd1);
    check("up_cur0",    {24'd0, cur[0]}, 32'h10);
    settle_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      do_tick(0);
      check("up_cur", {24'd0, cur[0]}, 32'h10 + 32'(k / 2));
      check("up_settled", {31'd0, setl[0]}, (k == 8) ? 32'd1 : 32'd0);
      check("up_ramp",    {31'd0, ramp[0]}, (k < 8) ? 32'd1 : 32'd0);
    end
    cyc();
    check("up_settled_once", {31'd0, setl[0]}, 32'd0);

    // Retarget mid-ramp: 0x20 -> 0x28, redirect to 0x1E at 0x22.
    goto_level(0, 8'h20);
    strobe(0, 8'h28);
    for (int k = 0; k < 4; k++) do_tick(0);
    check("rt_at22", {24'd0, cur[0]}, 32'h22);
    strobe(0, 8'h1E);
    check("rt_tgt", {24'd0, tgt[0]}, 32'h1E);
    settle_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      do_tick(0);
      if (setl[0]) settle_cnt++;
      if (k % 2 == 0)
        check("rt_cur", {24'd0, cur[0]}, 32'h22 - 32'(k / 2));
    end
    for (int k = 0; k < 4; k++) begin
      do_tick(0);
      if (setl[0]) settle_cnt++;
    end
    check("rt_no_overshoot", {24'd0, cur[0]}, 32'h1E);
    check("rt_settle_cnt", 32'(settle_cnt), 32'd1);

    // Request equal to current level.
    goto_level(0, 8'h40);
    cyc();
    strobe(0, 8'h40);
    check("eq_settled", {31'd0, setl[0]}, 32'd1);
    check("eq_ramping", {31'd0, ramp[0]}, 32'd0);
    do_tick(0);
    check("eq_settled_off", {31'd0, setl[0]}, 32'd0);
    for (int k = 0; k < 4; k++) do_tick(0);
    check("eq_cur_hold", {24'd0, cur[0]}, 32'h40);
    check("eq_ramp_hold", {31'd0, ramp[0]}, 32'd0);

    // Strobe and tick in the same cycle, STEP_DIV=1.
    goto_level(1, 8'h50);
    en[1] = 1'b1; bin[1] = 8'h52; tick[1] = 1'b1;
    cyc();
    en[1] = 1'b0; tick[1] = 1'b0;
    check("same_cur", {24'd0, cur[1]}, 32'h50);
    check("same_tgt", {24'd0, tgt[1]}, 32'h52);
    do_tick(1);
    check("same_step1", {24'd0, cur[1]}, 32'h51);
    do_tick(1);
    check("same_step2", {24'd0, cur[1]}, 32'h52);
    check("same_settled", {31'd0, setl[1]}, 32'd1);

    // Reset during a ramp.
    strobe(0, 8'h30);
    for (int k = 0; k < 4; k++) do_tick(0);
    check("mid_cur", {24'd0, cur[0]}, 32'h3E);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`else
    // Jump mode: 0xFF -> 0x00 lands on the next frame tick.
    strobe(0, 8'h00);
    check("jmp_tgt",     {24'd0, tgt[0]}, 32'h00);
    check("jmp_ramping", {31'd0, ramp[0]}, 32'd1);
    check("jmp_hold0",   {24'd0, cur[0]}, 32'hFF);
    cyc();
    cyc();
    check("jmp_hold1", {24'd0, cur[0]}, 32'hFF);
    do_tick(0);
    check("jmp_cur",     {24'd0, cur[0]}, 32'h00);
    check("jmp_settled", {31'd0, setl[0]}, 32'd1);
    check("jmp_ramp_off", {31'd0, ramp[0]}, 32'd0);
    cyc();
    check("jmp_settled_off", {31'd0, setl[0]}, 32'd0);

    // Request equal to current level.
    strobe(0, 8'h00);
    check("eq_settled", {31'd0, setl[0]}, 32'd1);
    check("eq_ramping", {31'd0, ramp[0]}, 32'd0);

    // Strobe with a same-cycle tick: tick ignored.
    en[0] = 1'b1; bin[0] = 8'h10; tick[0] = 1'b1;
    cyc();
    en[0] = 1'b0; tick[0] = 1'b0;
    check("same_cur", {24'd0, cur[0]}, 32'h00);
    do_tick(0);
    check("same_jump", {24'd0, cur[0]}, 32'h10);

    // Retarget back to current level while pending.
    strobe(0, 8'h20);
    strobe(0, 8'h10);
    check("rt_settled", {31'd0, setl[0]}, 32'd1);
    check("rt_ramping", {31'd0, ramp[0]}, 32'd0);
    check("rt_tgt",     {24'd0, tgt[0]}, 32'h10);

    // Reset while a jump is pending.
    strobe(0, 8'h55);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`endif
    check("mid_rst_cur",     {24'd0, cur[0]}, 32'hFF);
    check("mid_rst_tgt",     {24'd0, tgt[0]}, 32'hFF);
    check("mid_rst_ramping", {31'd0, ramp[0]}, 32'd0);
    check("mid_rst_settled", {31'd0, setl[0]}, 32'd0);
    do_tick(0);
    check("mid_rst_idle", {24'd0, cur[0]}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
